// File: rtl/vga_text_render.sv
// vga_text_render: character-mode VGA raster generator with text/font fetch, attribute colour and blinking cursor
// Ports: clk, reset_n (async active-low), pix_en (pixel-rate enable);
//        text_addr/text_data: text RAM (1 pix_en read latency); font_addr/font_data: font ROM (1 pix_en read latency);
//        cursor_en/cursor_col/cursor_row: block cursor; hsync/vsync (active-low), valid, vga_r/g/b: pixel outputs
//        delayed 3 pix_en from the raster counters; frame_start: pulse while the counters sit at (0,0).
module vga_text_render #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int FONT_W       = 9,
  parameter int FONT_H       = 16,
  parameter int COLS         = 70,
  parameter int ROWS         = 30,
  parameter int X_OFF        = 4,
  parameter int TADDR_W      = 12,
  parameter int FADDR_W      = 12,
  parameter int BLINK_FRAMES = 30
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pix_en,
  output logic [TADDR_W-1:0] text_addr,
  input  logic [15:0]        text_data,
  output logic [FADDR_W-1:0] font_addr,
  input  logic [FONT_W-1:0]  font_data,
  input  logic               cursor_en,
  input  logic [7:0]         cursor_col,
  input  logic [7:0]         cursor_row,
  output logic               hsync,
  output logic               vsync,
  output logic               valid,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int GXW = $clog2(FONT_W + 1);
  localparam int GYW = FADDR_W - 8;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_X0 = HW'(X_OFF);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [GXW-1:0] GX_LAST = GXW'(FONT_W - 1);
  localparam logic [GYW-1:0] GY_LAST = GYW'(FONT_H - 1);
  localparam logic [7:0] COLS8 = 8'(COLS);
  localparam logic [7:0] ROWS8 = 8'(ROWS);
  localparam logic [TADDR_W-1:0] COLS_A = TADDR_W'(COLS);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_FRAMES - 1);

  logic [HW-1:0] h, h_nxt;
  logic [VW-1:0] v, v_nxt;
  logic [GXW-1:0] gx, gx1, gx2;
  logic [GYW-1:0] gy, gy1;
  logic [7:0] col, row;
  logic [TADDR_W-1:0] row_base;
  logic [BW-1:0] blink_cnt;
  logic blink_ph;
  logic h_wrap, v_wrap, vis0, cell0, hit0, hs0, vs0;
  logic vis1, cell1, hit1, hs1, vs1;
  logic vis2, cell2, hit2, hs2, vs2;
  logic [7:0] attr2;
  logic [3:0] fg, bg, idx;
  logic [7:0] lvl;
  logic show;

  assign h_wrap = h == H_LAST;
  assign v_wrap = v == V_LAST;
  assign h_nxt = h_wrap ? '0 : h + 1'b1;
  assign v_nxt = h_wrap ? (v_wrap ? '0 : v + 1'b1) : v;
  assign vis0 = h < H_VIS && v < V_VIS;
  assign cell0 = vis0 && h >= H_X0 && col < COLS8 && row < ROWS8;
  // cell0 gating keeps the cursor inside the text grid even for out-of-range coordinates
  assign hit0 = cell0 && cursor_en && blink_ph && col == cursor_col && row == cursor_row;
  assign hs0 = !(h >= HS_BEG && h < HS_END);
  assign vs0 = !(v >= VS_BEG && v < VS_END);
  // address 0 outside the grid so nothing beyond COLS*ROWS ever reaches the RAM
  assign text_addr = cell0 ? row_base + TADDR_W'(col) : '0;
  assign font_addr = FADDR_W'({text_data[7:0], gy1});

  assign fg = hit2 ? attr2[7:4] : attr2[3:0];
  assign bg = hit2 ? attr2[3:0] : attr2[7:4];
  assign idx = font_data[gx2] ? fg : bg;
  assign lvl = idx[3] ? 8'hFF : 8'hAA;
  assign show = cell2 && vis2;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h <= '0;
      v <= '0;
      gx <= '0;
      col <= '0;
      gy <= '0;
      row <= '0;
      row_base <= '0;
      blink_cnt <= '0;
      blink_ph <= 1'b1;
      frame_start <= 1'b0;
      {vis1, cell1, hit1, hs1, vs1, gx1, gy1} <= {3'b000, 2'b11, {GXW{1'b0}}, {GYW{1'b0}}};
      {vis2, cell2, hit2, hs2, vs2, gx2, attr2} <= {3'b000, 2'b11, {GXW{1'b0}}, 8'h00};
      {hsync, vsync, valid} <= 3'b110;
      {vga_r, vga_g, vga_b} <= '0;
    end else if (pix_en) begin
      h <= h_nxt;
      v <= v_nxt;
      frame_start <= h_nxt == '0 && v_nxt == '0;
      if (h_wrap) begin
        gx <= '0;
        col <= '0;
      end else if (h >= H_X0) begin
        gx <= gx == GX_LAST ? '0 : gx + 1'b1;
        if (gx == GX_LAST && col < COLS8) col <= col + 1'b1;
      end
      if (h_wrap) begin
        if (v_wrap) begin
          gy <= '0;
          row <= '0;
          row_base <= '0;
        end else if (gy == GY_LAST) begin
          gy <= '0;
          if (row < ROWS8) begin
            row <= row + 1'b1;
            row_base <= row_base + COLS_A;
          end
        end else gy <= gy + 1'b1;
      end
      if (frame_start) begin
        blink_cnt <= blink_cnt == BL_LAST ? '0 : blink_cnt + 1'b1;
        if (blink_cnt == BL_LAST) blink_ph <= ~blink_ph;
      end
      {vis1, cell1, hit1, hs1, vs1, gx1, gy1} <= {vis0, cell0, hit0, hs0, vs0, gx, gy};
      {vis2, cell2, hit2, hs2, vs2, gx2, attr2} <= {vis1, cell1, hit1, hs1, vs1, gx1, text_data[15:8]};
      {hsync, vsync, valid} <= {hs2, vs2, vis2};
      vga_r <= show && idx[2] ? lvl : '0;
      vga_g <= show && idx[1] ? lvl : '0;
      vga_b <= show && idx[0] ? lvl : '0;
    end
endmodule

// File: tb/tb_vga_text_render.sv
// tb_vga_text_render: scoreboard plus directed pixel table for vga_text_render on a reduced raster
module tb_vga_text_render;
  localparam int HA = 80, HF = 4, HS = 8, HB = 8, VA = 40, VF = 2, VS = 2, VB = 4;
  localparam int FW = 9, FH = 16, NC = 8, NR = 2, XO = 4, BF = 3;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FT = HT * VT;

  typedef struct {logic hs, vs, vd; logic [23:0] rgb; int p;} exp_t;
  typedef struct {int f, x, y; logic [23:0] rgb;} vec_t;

  logic clk = 0, reset_n = 0, pix_en = 0;
  logic [11:0] text_addr, font_addr;
  logic [15:0] text_data = '0;
  logic [8:0] font_data = '0;
  logic cursor_en = 0;
  logic [7:0] cursor_col = 0, cursor_row = 0;
  logic hsync, vsync, valid, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;
  logic [15:0] tram [0:4095];
  logic [8:0] fram [0:4095];
  exp_t q[$];
  exp_t last, rst_e;
  vec_t vt[16];
  int tests = 0, fails = 0, pos = 0, vhits = 0, first_hs = -1;
  int vcnt = 0, vlow = 0, vfirst = -1, lastf = -1, fs_cnt = 0;
  bit armed = 0, efs = 0, prev_hs = 1;

  always #5 clk = ~clk;

  always @(posedge clk) if (pix_en) begin
    text_data <= tram[text_addr];
    font_data <= fram[font_addr];
  end

  vga_text_render #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FONT_W(FW), .FONT_H(FH), .COLS(NC), .ROWS(NR), .X_OFF(XO),
    .TADDR_W(12), .FADDR_W(12), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .text_addr(text_addr), .text_data(text_data),
    .font_addr(font_addr), .font_data(font_data),
    .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
  );

  task automatic cmp(input string n, input logic [23:0] act, input logic [23:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s pos=%0d actual=%h required=%h", n, pos, act, req);
    end
  endtask

  function automatic logic [7:0] chan(input logic [3:0] i, input int b);
    return i[b] ? (i[3] ? 8'hFF : 8'hAA) : 8'h00;
  endfunction

  function automatic int exp_ta(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    if (h < HA && v < VA && h >= XO && (h - XO) / FW < NC && v / FH < NR) return (v / FH) * NC + (h - XO) / FW;
    return 0;
  endfunction

  // reference pixel from absolute raster position, using division rather than counters
  function automatic exp_t model(input int p);
    exp_t e;
    int h, v, f, c, r, gx, gy;
    logic [15:0] w;
    logic [8:0] g;
    logic [3:0] idx;
    bit hit;
    h = p % HT;
    v = (p / HT) % VT;
    f = p / FT;
    e.p = p;
    e.hs = !(h >= HA + HF && h < HA + HF + HS);
    e.vs = !(v >= VA + VF && v < VA + VF + VS);
    e.vd = h < HA && v < VA;
    e.rgb = '0;
    if (e.vd && h >= XO) begin
      c = (h - XO) / FW;
      gx = (h - XO) % FW;
      r = v / FH;
      gy = v % FH;
      if (c < NC && r < NR) begin
        w = tram[r * NC + c];
        g = fram[{w[7:0], 4'(gy)}];
        hit = cursor_en && c == int'(cursor_col) && r == int'(cursor_row) && (f / BF) % 2 == 0;
        idx = (g[gx] ^ hit) ? w[11:8] : w[15:12];
        e.rgb = {chan(idx, 2), chan(idx, 1), chan(idx, 0)};
      end
    end
    return e;
  endfunction

  task automatic observe(input exp_t e);
    for (int i = 0; i < 16; i++)
      if (vt[i].f == e.p / FT && vt[i].x == e.p % HT && vt[i].y == (e.p / HT) % VT) begin
        vhits++;
        cmp($sformatf("vec%0d", i), {vga_r, vga_g, vga_b}, vt[i].rgb);
      end
    if (!hsync && first_hs < 0) first_hs = pos;
    if (frame_start) fs_cnt++;
    if (e.p / FT == 1) begin
      vcnt += int'(valid);
      vlow += int'(!vsync);
      if (!vsync && vfirst < 0) vfirst = e.p - FT;
      if (prev_hs && !hsync) begin
        if (lastf >= 0) cmp("hsync_period", 24'(pos - lastf), 24'(HT));
        lastf = pos;
      end
    end
    prev_hs = hsync;
  endtask

  task automatic step(input bit en);
    exp_t e;
    pix_en = en;
    if (en) begin
      q.push_back(model(pos));
      cmp("text_addr", 24'(text_addr), 24'(exp_ta(pos)));
    end
    @(negedge clk);
    if (en) begin
      pos++;
      last = q.pop_front();
      efs = pos % FT == 0;
    end
    e = last;
    cmp("hsync", 24'(hsync), 24'(e.hs));
    cmp("vsync", 24'(vsync), 24'(e.vs));
    cmp("valid", 24'(valid), 24'(e.vd));
    cmp("rgb", {vga_r, vga_g, vga_b}, e.rgb);
    cmp("frame_start", 24'(frame_start), 24'(efs));
    if (en && armed && e.p >= 0) observe(e);
  endtask

  task automatic release_reset();
    reset_n = 1;
    pos = 0;
    q.delete();
    q.push_back(rst_e);
    q.push_back(rst_e);
    last = rst_e;
    efs = 0;
  endtask

  task automatic run_to(input int p);
    while (pos < p) step(1);
  endtask

  initial begin
    vt[0] = '{0, 4, 0, 24'hFFFFFF};
    vt[1] = '{0, 5, 0, 24'h000000};
    vt[2] = '{0, 67, 0, 24'h0000AA};
    vt[3] = '{0, 75, 3, 24'h0000AA};
    vt[4] = '{0, 76, 0, 24'h000000};
    vt[5] = '{0, 79, 0, 24'h000000};
    vt[6] = '{0, 22, 16, 24'h000000};
    vt[7] = '{1, 30, 31, 24'h000000};
    vt[8] = '{2, 22, 16, 24'h000000};
    vt[9] = '{3, 22, 16, 24'hAAAAAA};
    vt[10] = '{5, 26, 20, 24'hAAAAAA};
    vt[11] = '{6, 22, 16, 24'h000000};
    vt[12] = '{6, 22, 20, 24'hAAAAAA};
    vt[13] = '{1, 80, 0, 24'h000000};
    vt[14] = '{1, 3, 0, 24'h000000};
    vt[15] = '{6, 22, 28, 24'hAAAAAA};
    rst_e = '{1'b1, 1'b1, 1'b0, 24'h0, -1};
    for (int i = 0; i < 4096; i++) begin
      tram[i] = 16'($urandom);
      fram[i] = 9'($urandom);
    end
    tram[0] = 16'h0F41;
    tram[7] = 16'h1C42;
    tram[10] = 16'h0743;
    fram[12'h410] = 9'b000000001;
    for (int r = 0; r < 16; r++) begin
      fram[12'h420 + r] = '0;
      fram[12'h430 + r] = '1;
    end
    cursor_en = 1;
    cursor_col = 2;
    cursor_row = 1;
    pix_en = 1;
    repeat (3) @(negedge clk);
    release_reset();
    run_to(2 * HT + 30);
    #2 reset_n = 0;
    #1;
    for (int i = 0; i < 4; i++) begin
      cmp("rst_hsync", 24'(hsync), 24'(1));
      cmp("rst_vsync", 24'(vsync), 24'(1));
      cmp("rst_valid", 24'(valid), 24'(0));
      cmp("rst_rgb", {vga_r, vga_g, vga_b}, 24'h0);
      cmp("rst_frame_start", 24'(frame_start), 24'(0));
      @(negedge clk);
    end
    release_reset();
    armed = 1;
    for (int i = 0; i < 120; i++) begin
      step(1);
      repeat (3) step(0);
    end
    run_to(FT + 5 * HT + 50);
    repeat (50) step(0);
    run_to(6 * FT + 18 * HT);
    cursor_col = 3;
    run_to(6 * FT + 24 * HT);
    cursor_col = 8;
    run_to(6 * FT + 40 * HT);
    cursor_col = 2;
    run_to(7 * FT + 10);
    cmp("vec_hits", 24'(vhits), 24'(16));
    cmp("first_hsync_low", 24'(first_hs), 24'(HA + HF + 3));
    cmp("valid_count", 24'(vcnt), 24'(HA * VA));
    cmp("vsync_low_len", 24'(vlow), 24'(VS * HT));
    cmp("vsync_first", 24'(vfirst), 24'((VA + VF) * HT));
    cmp("frame_start_count", 24'(fs_cnt), 24'(7));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
